// File: rtl/ex_stage_if.sv
// Decode <-> execute stage bus: decoded operands in, forwarding/result/stall out.
interface ex_stage_if #(
   parameter int WORD_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5
);
   logic [7:0]                i_exop;
   logic [WORD_WIDTH-1:0]     i_srcLeft;
   logic [WORD_WIDTH-1:0]     i_srcRight;
   logic [WORD_WIDTH-1:0]     i_offset;
   logic [REG_ADDR_WIDTH-1:0] i_dest;
   logic                      i_idStall;
   logic [REG_ADDR_WIDTH-1:0] o_exDest;
   logic [WORD_WIDTH-1:0]     o_exResult;
   logic                      o_exWriteEnable;
   logic                      o_exStall;

   modport master (
      output i_exop, i_srcLeft, i_srcRight, i_offset, i_dest, i_idStall,
      input  o_exDest, o_exResult, o_exWriteEnable, o_exStall
   );

   modport slave (
      input  i_exop, i_srcLeft, i_srcRight, i_offset, i_dest, i_idStall,
      output o_exDest, o_exResult, o_exWriteEnable, o_exStall
   );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: ID_EX latch, single-cycle logic/shift/arith ALU and a restoring divider FSM.
// Optional signed DIV/REM (DIV class subs 2/3) enabled by defining EX_SIGNED_DIV_EN.
module ex_stage #(
   parameter int WORD_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int DIV_CYCLES     = 32
) (
   input  logic      clk,
   input  logic      rst_n,
   ex_stage_if.slave bus
);
   localparam int                CNT_W    = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DIV_CYCLES - 1);
   localparam logic [2:0]        CLS_LOGIC = 3'b001;
   localparam logic [2:0]        CLS_SHIFT = 3'b010;
   localparam logic [2:0]        CLS_ARITH = 3'b011;
   localparam logic [2:0]        CLS_DIV   = 3'b100;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                         state_p1, state_nxt;
   logic [7:0]                     op_p0;
   logic signed [WORD_WIDTH-1:0]   left_p0, right_p0;
   logic [4:0]                     shamt_p0;
   logic [REG_ADDR_WIDTH-1:0]      dest_p0;
   logic [2:0]                     cls_p0;
   logic [4:0]                     sub_p0;
   logic                           vld_p0;
   logic [WORD_WIDTH-1:0]          alu_res;
   logic                           div_op, div_signed, div_rem, div_zero;
   logic                           stall;
   logic [CNT_W-1:0]               cnt_p1;
   logic [WORD_WIDTH-1:0]          quo_p1, rem_p1, dvsr_p1;
   logic                           neg_q_p1, neg_r_p1;
   logic [WORD_WIDTH:0]            rem_sh, rem_sub;
   logic                           step_ge;
   logic                           unused_offset;

   function automatic logic [WORD_WIDTH-1:0] magnitude(input logic signed [WORD_WIDTH-1:0] v);
      logic [WORD_WIDTH-1:0] u;
      u = $unsigned(v);
      return v[WORD_WIDTH-1] ? (~u + 1'b1) : u;
   endfunction

   function automatic logic [WORD_WIDTH-1:0] apply_sign(input logic [WORD_WIDTH-1:0] v,
                                                         input logic neg);
      return neg ? (~v + 1'b1) : v;
   endfunction

   assign unused_offset = ^bus.i_offset[WORD_WIDTH-1:5];

   // ---- ID_EX latch (p0): stall holds, decode stall inserts a bubble ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_p0    <= '0;
         left_p0  <= '0;
         right_p0 <= '0;
         shamt_p0 <= '0;
         dest_p0  <= '0;
      end else if (!stall) begin
         if (bus.i_idStall) begin
            op_p0   <= '0;
            dest_p0 <= '0;
         end else begin
            op_p0    <= bus.i_exop;
            left_p0  <= bus.i_srcLeft;
            right_p0 <= bus.i_srcRight;
            shamt_p0 <= bus.i_offset[4:0];
            dest_p0  <= bus.i_dest;
         end
      end
   end

   assign cls_p0   = op_p0[7:5];
   assign sub_p0   = op_p0[4:0];
   assign div_rem  = sub_p0[0];
   assign div_zero = (right_p0 == '0);

`ifdef EX_SIGNED_DIV_EN
   assign div_op     = (cls_p0 == CLS_DIV) && (sub_p0 < 5'd4);
   assign div_signed = sub_p0[1];
`else
   assign div_op     = (cls_p0 == CLS_DIV) && (sub_p0 < 5'd2);
   assign div_signed = 1'b0;
`endif

   always_comb begin
      alu_res = '0;
      vld_p0  = 1'b0;
      case (cls_p0)
         CLS_LOGIC: begin
            vld_p0 = (sub_p0 < 5'd4);
            case (sub_p0)
               5'd0:    alu_res = left_p0 | right_p0;
               5'd1:    alu_res = left_p0 & right_p0;
               5'd2:    alu_res = left_p0 ^ right_p0;
               5'd3:    alu_res = ~(left_p0 | right_p0);
               default: alu_res = '0;
            endcase
         end
         CLS_SHIFT: begin
            vld_p0 = (sub_p0 < 5'd3);
            case (sub_p0)
               5'd0:    alu_res = $unsigned(right_p0) << shamt_p0;
               5'd1:    alu_res = $unsigned(right_p0) >> shamt_p0;
               5'd2:    alu_res = $unsigned(right_p0 >>> shamt_p0);
               default: alu_res = '0;
            endcase
         end
         CLS_ARITH: begin
            vld_p0 = (sub_p0 < 5'd4);
            case (sub_p0)
               5'd0:    alu_res = left_p0 + right_p0;
               5'd1:    alu_res = left_p0 - right_p0;
               5'd2:    alu_res = {{(WORD_WIDTH-1){1'b0}}, (left_p0 < right_p0)};
               5'd3:    alu_res = {{(WORD_WIDTH-1){1'b0}},
                                   ($unsigned(left_p0) < $unsigned(right_p0))};
               default: alu_res = '0;
            endcase
         end
         default: alu_res = '0;
      endcase
   end

   // ---- divider (p1): one restoring shift-subtract step per RUN cycle ----
   assign rem_sh  = {rem_p1, quo_p1[WORD_WIDTH-1]};
   assign rem_sub = rem_sh - {1'b0, dvsr_p1};
   assign step_ge = ~rem_sub[WORD_WIDTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_p1 <= IDLE;
      else        state_p1 <= state_nxt;
   end

   always_comb begin
      state_nxt = state_p1;
      stall     = 1'b0;
      case (state_p1)
         IDLE: begin
            if (div_op) begin
               stall     = 1'b1;
               state_nxt = div_zero ? DONE : RUN;
            end
         end
         RUN: begin
            stall = 1'b1;
            if (cnt_p1 == CNT_LAST) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_p1   <= '0;
         neg_q_p1 <= 1'b0;
         neg_r_p1 <= 1'b0;
      end else begin
         case (state_p1)
            IDLE: begin
               if (div_op) begin
                  cnt_p1   <= '0;
                  // Divide-by-zero returns raw values, so no sign fixup.
                  neg_q_p1 <= div_signed && !div_zero &&
                              (left_p0[WORD_WIDTH-1] ^ right_p0[WORD_WIDTH-1]);
                  neg_r_p1 <= div_signed && !div_zero && left_p0[WORD_WIDTH-1];
               end
            end
            RUN:     cnt_p1 <= cnt_p1 + 1'b1;
            default: cnt_p1 <= cnt_p1;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (state_p1 == IDLE && div_op) begin
         if (div_zero) begin
            quo_p1  <= '1;
            rem_p1  <= left_p0;
            dvsr_p1 <= '0;
         end else begin
            quo_p1  <= div_signed ? magnitude(left_p0) : $unsigned(left_p0);
            rem_p1  <= '0;
            dvsr_p1 <= div_signed ? magnitude(right_p0) : $unsigned(right_p0);
         end
      end else if (state_p1 == RUN) begin
         quo_p1 <= {quo_p1[WORD_WIDTH-2:0], step_ge};
         rem_p1 <= step_ge ? rem_sub[WORD_WIDTH-1:0] : rem_sh[WORD_WIDTH-1:0];
      end
   end

   // ---- outputs: forwarding and EX_MEM ----
   always_comb begin
      bus.o_exResult      = '0;
      bus.o_exWriteEnable = 1'b0;
      if (state_p1 == DONE) begin
         bus.o_exResult      = div_rem ? apply_sign(rem_p1, neg_r_p1)
                                       : apply_sign(quo_p1, neg_q_p1);
         bus.o_exWriteEnable = (dest_p0 != '0);
      end else if (!div_op) begin
         bus.o_exResult      = alu_res;
         bus.o_exWriteEnable = vld_p0 && (dest_p0 != '0);
      end
   end

   assign bus.o_exDest  = dest_p0;
   assign bus.o_exStall = stall;
endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: scoreboard monitor on writeEnable plus inline stall/bubble checks.
module tb_ex_stage;
   localparam logic [7:0] OP_NOP  = 8'h00;
   localparam logic [7:0] OP_OR   = {3'b001, 5'd0};
   localparam logic [7:0] OP_AND  = {3'b001, 5'd1};
   localparam logic [7:0] OP_XOR  = {3'b001, 5'd2};
   localparam logic [7:0] OP_NOR  = {3'b001, 5'd3};
   localparam logic [7:0] OP_SLL  = {3'b010, 5'd0};
   localparam logic [7:0] OP_SRL  = {3'b010, 5'd1};
   localparam logic [7:0] OP_SRA  = {3'b010, 5'd2};
   localparam logic [7:0] OP_ADD  = {3'b011, 5'd0};
   localparam logic [7:0] OP_SUB  = {3'b011, 5'd1};
   localparam logic [7:0] OP_SLT  = {3'b011, 5'd2};
   localparam logic [7:0] OP_SLTU = {3'b011, 5'd3};
   localparam logic [7:0] OP_DIVU = {3'b100, 5'd0};
   localparam logic [7:0] OP_REMU = {3'b100, 5'd1};
   localparam logic [7:0] OP_DIV  = {3'b100, 5'd2};
   localparam logic [7:0] OP_REM  = {3'b100, 5'd3};

   typedef struct packed {
      logic [4:0]  dest;
      logic [31:0] res;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   exp_t sb[$];
   exp_t mon_e;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   ex_stage_if #(.WORD_WIDTH(32), .REG_ADDR_WIDTH(5)) bus ();

   ex_stage #(.WORD_WIDTH(32), .REG_ADDR_WIDTH(5), .DIV_CYCLES(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1 && bus.o_exWriteEnable === 1'b1) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected: dest=%0d result=0x%08h with nothing pending",
                     bus.o_exDest, bus.o_exResult);
         end else begin
            mon_e = sb.pop_front();
            if (bus.o_exDest !== mon_e.dest || bus.o_exResult !== mon_e.res) begin
               bad++;
               $display("FAIL sb_result: got dest=%0d res=0x%08h expected dest=%0d res=0x%08h",
                        bus.o_exDest, bus.o_exResult, mon_e.dest, mon_e.res);
            end
         end
      end
   end

   task automatic set_in(input logic [7:0] op, input logic [31:0] l, input logic [31:0] r,
                         input logic [31:0] off, input logic [4:0] d, input logic ids);
      bus.i_exop      = op;
      bus.i_srcLeft   = l;
      bus.i_srcRight  = r;
      bus.i_offset    = off;
      bus.i_dest      = d;
      bus.i_idStall   = ids;
   endtask

   task automatic issue(input logic [7:0] op, input logic [31:0] l, input logic [31:0] r,
                        input logic [31:0] off, input logic [4:0] d, input logic exp_we,
                        input logic [31:0] exp_res, input string name);
      exp_t e;
      set_in(op, l, r, off, d, 1'b0);
      if (exp_we) begin
         e = {d, exp_res};
         sb.push_back(e);
      end
      @(posedge clk); #1;
      chk({name, "_we"}, {31'b0, bus.o_exWriteEnable}, {31'b0, exp_we});
      chk({name, "_stall"}, {31'b0, bus.o_exStall}, 32'd0);
      if (!exp_we) chk({name, "_res"}, bus.o_exResult, exp_res);
   endtask

   task automatic run_div(input logic [7:0] op, input logic [31:0] l, input logic [31:0] r,
                          input logic [4:0] d, input int exp_stalls, input logic [31:0] exp_res,
                          input logic stall_ids, input string name);
      int   n    = 0;
      int   badc = 0;
      exp_t e;
      set_in(op, l, r, 32'd0, d, 1'b0);
      if (d != 5'd0) begin
         e = {d, exp_res};
         sb.push_back(e);
      end
      e = {5'd11, 32'h0000_00FF};
      sb.push_back(e);
      @(posedge clk); #1;
      set_in(OP_OR, 32'h0F, 32'hF0, 32'd0, 5'd11, 1'b0);
      while (n < 200) begin
         @(negedge clk);
         if (bus.o_exStall !== 1'b1) break;
         n++;
         if (bus.o_exDest !== d || bus.o_exWriteEnable !== 1'b0) badc++;
         if (stall_ids) bus.i_idStall = (n >= 3 && n < 8);
      end
      bus.i_idStall = 1'b0;
      chk({name, "_stall_cycles"}, n, exp_stalls);
      chk({name, "_stall_hold"}, badc, 0);
      chk({name, "_res"}, bus.o_exResult, exp_res);
      chk({name, "_we"}, {31'b0, bus.o_exWriteEnable}, {31'b0, (d != 5'd0)});
      @(posedge clk); #1;
      chk({name, "_next_dest"}, {27'b0, bus.o_exDest}, 32'd11);
      chk({name, "_next_we"}, {31'b0, bus.o_exWriteEnable}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish within the time budget");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0;
      set_in(OP_NOP, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_res",   bus.o_exResult, 32'd0);
      chk("rst_dest",  {27'b0, bus.o_exDest}, 32'd0);
      chk("rst_we",    {31'b0, bus.o_exWriteEnable}, 32'd0);
      chk("rst_stall", {31'b0, bus.o_exStall}, 32'd0);
      rst_n = 1'b1;

      // ALU sweep, back to back
      issue(OP_OR,   32'h0000_000F, 32'h0000_00F0, 32'd0, 5'd3, 1'b1, 32'h0000_00FF, "or");
      issue(OP_AND,  32'hFF00_FF00, 32'h0FF0_0FF0, 32'd0, 5'd4, 1'b1, 32'h0F00_0F00, "and");
      issue(OP_XOR,  32'hFFFF_0000, 32'h0F0F_0F0F, 32'd0, 5'd5, 1'b1, 32'hF0F0_0F0F, "xor");
      issue(OP_NOR,  32'h0000_FFFF, 32'h00FF_0000, 32'd0, 5'd6, 1'b1, 32'hFF00_0000, "nor");
      issue(OP_SLL,  32'h1234_5678, 32'h0000_0003, 32'h24, 5'd7, 1'b1, 32'h0000_0030, "sll");
      issue(OP_SRL,  32'd0, 32'h8000_0000, 32'd4, 5'd8, 1'b1, 32'h0800_0000, "srl");
      issue(OP_SRA,  32'd0, 32'h8000_0000, 32'd4, 5'd9, 1'b1, 32'hF800_0000, "sra");
      issue(OP_ADD,  32'hFFFF_FFFF, 32'd2, 32'd0, 5'd10, 1'b1, 32'h0000_0001, "add");
      issue(OP_SUB,  32'd0, 32'd1, 32'd0, 5'd12, 1'b1, 32'hFFFF_FFFF, "sub");
      issue(OP_SLT,  32'hFFFF_FFFF, 32'd1, 32'd0, 5'd13, 1'b1, 32'd1, "slt");
      issue(OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd14, 1'b1, 32'd0, "sltu");
      issue(OP_ADD,  32'd5, 32'd7, 32'd0, 5'd0, 1'b0, 32'd12, "add_dest0");
      issue({3'b001, 5'd4}, 32'd5, 32'd7, 32'd0, 5'd3, 1'b0, 32'd0, "bad_sub");
      issue({3'b111, 5'd0}, 32'd5, 32'd7, 32'd0, 5'd3, 1'b0, 32'd0, "bad_class");

      // Decode stall on a non-div op inserts one bubble
      issue(OP_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'd0, 5'd9, 1'b1, 32'h0F00_0F00, "and_pre");
      set_in(OP_XOR, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'd0, 5'd10, 1'b1);
      @(posedge clk); #1;
      chk("bubble_we",   {31'b0, bus.o_exWriteEnable}, 32'd0);
      chk("bubble_dest", {27'b0, bus.o_exDest}, 32'd0);
      chk("bubble_res",  bus.o_exResult, 32'd0);
      issue(OP_XOR, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'd0, 5'd10, 1'b1, 32'hF0F0_0F0F, "xor_post");

      // Unsigned divider
      run_div(OP_DIVU, 32'd100, 32'd7, 5'd5, 33, 32'd14, 1'b0, "divu");
      run_div(OP_REMU, 32'd100, 32'd7, 5'd5, 33, 32'd2, 1'b1, "remu_idstall");
      run_div(OP_DIVU, 32'h1234, 32'd0, 5'd12, 1, 32'hFFFF_FFFF, 1'b0, "divu_zero");
      run_div(OP_REMU, 32'h1234, 32'd0, 5'd12, 1, 32'h0000_1234, 1'b0, "remu_zero");
      run_div(OP_DIVU, 32'hFFFF_FFFF, 32'd3, 5'd14, 33, 32'h5555_5555, 1'b0, "divu_big");
      run_div(OP_REMU, 32'hFFFF_FFFF, 32'h10, 5'd0, 33, 32'h0000_000F, 1'b0, "remu_dest0");
      run_div(OP_DIVU, 32'd7, 32'd9, 5'd15, 33, 32'd0, 1'b0, "divu_small");

`ifdef EX_SIGNED_DIV_EN
      run_div(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd13, 33, 32'hFFFF_FFFD, 1'b0, "div_neg");
      run_div(OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd13, 33, 32'hFFFF_FFFF, 1'b0, "rem_neg");
      run_div(OP_DIV, 32'd7, 32'hFFFF_FFFE, 5'd13, 33, 32'hFFFF_FFFD, 1'b0, "div_negd");
      run_div(OP_REM, 32'd7, 32'hFFFF_FFFE, 5'd13, 33, 32'd1, 1'b0, "rem_negd");
      run_div(OP_REM, 32'hFFFF_FFF8, 32'd0, 5'd13, 1, 32'hFFFF_FFF8, 1'b0, "rem_zero_s");
`else
      issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'd0, 5'd13, 1'b0, 32'd0, "div_disabled");
      issue(OP_REM, 32'hFFFF_FFF9, 32'd2, 32'd0, 5'd13, 1'b0, 32'd0, "rem_disabled");
`endif

      // Reset in the middle of a divide
      set_in(OP_DIVU, 32'd100, 32'd7, 32'd0, 5'd5, 1'b0);
      @(posedge clk); #1;
      set_in(OP_NOP, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
      repeat (12) @(negedge clk);
      chk("mid_div_stall", {31'b0, bus.o_exStall}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_res",   bus.o_exResult, 32'd0);
      chk("mid_rst_dest",  {27'b0, bus.o_exDest}, 32'd0);
      chk("mid_rst_we",    {31'b0, bus.o_exWriteEnable}, 32'd0);
      chk("mid_rst_stall", {31'b0, bus.o_exStall}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      issue(OP_OR, 32'h0000_000F, 32'h0000_00F0, 32'd0, 5'd3, 1'b1, 32'h0000_00FF, "post_rst_or");

      set_in(OP_NOP, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("sb_drained", sb.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
